// File: rtl/sram_scan_ctrl.sv
// Serial scan-chain front end for one or two SRAM macros: a frame is shifted in on gpio_in, fired with gpio_global_csb.
// Read data is folded back into the frame on load. Macro strobes are one cycle behind the sampled access strobe; there is no backpressure.
module sram_scan_ctrl #(
   parameter int SEL_W     = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int WMASK_W   = 4,
   parameter int NUM_PORTS = 2
) (
   input  logic               gpio_clk,
   input  logic               gpio_resetn,
   input  logic               gpio_scan,
   input  logic               gpio_sram_load,
   input  logic               gpio_global_csb,
   input  logic               gpio_in,
   output logic               gpio_out,
   output logic [SEL_W-1:0]   sel,
   output logic               csb_0,
   output logic               web_0,
   output logic [WMASK_W-1:0] wmask_0,
   output logic [ADDR_W-1:0]  addr_0,
   output logic [DATA_W-1:0]  din_0,
   input  logic [DATA_W-1:0]  dout_0,
   output logic               csb_1,
   output logic               web_1,
   output logic [WMASK_W-1:0] wmask_1,
   output logic [ADDR_W-1:0]  addr_1,
   output logic [DATA_W-1:0]  din_1,
   input  logic [DATA_W-1:0]  dout_1,
   output logic               frame_err,
   output logic               busy
);

   localparam int PORT_W  = ADDR_W + DATA_W + 2 + WMASK_W;
   localparam int FRAME_W = SEL_W + NUM_PORTS * PORT_W;
   localparam int CNT_W   = $clog2(FRAME_W);

   typedef enum logic [2:0] {IDLE, SHIFT, ARMED, ACCESS, CAPTURE} state_t;

   state_t               state_q;
   logic [FRAME_W-1:0]   scan_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [FRAME_W-1:0]   scan_ld_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [DATA_W-1:0]    dout_q [2];
   logic [DATA_W-1:0]    dout_in [2];
   logic [1:0]           csb_q;
   logic                 err_q;

   logic [ADDR_W-1:0]    f_addr  [2];
   logic [DATA_W-1:0]    f_din   [2];
   logic [WMASK_W-1:0]   f_wmask [2];
   logic [1:0]           f_csb;
   logic [1:0]           f_web;
   logic [1:0]           rd;

   assign dout_in[0] = dout_0;
   assign dout_in[1] = dout_1;

   // Fields decode from the frame latched on entry to ARMED, so scanning during an access cannot disturb the macro pins.
   for (genvar p = 0; p < 2; p++) begin : g_port
      if (p < NUM_PORTS) begin : g_on
         localparam int PB = (NUM_PORTS - 1 - p) * PORT_W;
         assign f_addr[p]  = frame_q[PB+PORT_W-1 -: ADDR_W];
         assign f_din[p]   = frame_q[PB+WMASK_W+2 +: DATA_W];
         assign f_csb[p]   = frame_q[PB+WMASK_W+1];
         assign f_web[p]   = frame_q[PB+WMASK_W];
         assign f_wmask[p] = frame_q[PB +: WMASK_W];
      end else begin : g_off
         assign f_addr[p]  = '0;
         assign f_din[p]   = '0;
         assign f_csb[p]   = 1'b1;
         assign f_web[p]   = 1'b1;
         assign f_wmask[p] = '0;
      end
   end

   assign rd = ~f_csb & f_web;

   always_comb begin
      scan_ld_d = scan_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rd[p]) begin
            scan_ld_d[(NUM_PORTS-1-p)*PORT_W+WMASK_W+2 +: DATA_W] = dout_q[p];
         end
      end
   end

   assign cnt_d = (cnt_q == CNT_W'(FRAME_W - 1)) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge gpio_clk or negedge gpio_resetn) begin
      if (!gpio_resetn) begin
         state_q   <= IDLE;
         scan_q    <= '0;
         frame_q   <= '0;
         cnt_q     <= '0;
         dout_q[0] <= '0;
         dout_q[1] <= '0;
         csb_q     <= '1;
         err_q     <= 1'b0;
      end else begin
         // Load outranks scan: a load cycle never shifts.
         if (gpio_sram_load) begin
            cnt_q <= '0;
            if (state_q == CAPTURE) scan_q <= scan_ld_d;
         end else if (gpio_scan) begin
            scan_q <= {scan_q[FRAME_W-2:0], gpio_in};
            cnt_q  <= cnt_d;
         end

         csb_q <= '1;
         case (state_q)
            IDLE: begin
               if (!gpio_sram_load && gpio_scan) state_q <= SHIFT;
            end
            SHIFT: begin
               if (!gpio_scan) begin
                  if (cnt_q == '0 && !err_q) begin
                     state_q <= ARMED;
                     frame_q <= scan_q;
                  end else begin
                     state_q <= IDLE;
                     if (cnt_q != '0) err_q <= 1'b1;
                  end
               end
            end
            ARMED: begin
               if (gpio_sram_load) begin
                  state_q <= IDLE;
               end else if (gpio_scan) begin
                  state_q <= SHIFT;
               end else if (!gpio_global_csb) begin
                  state_q <= ACCESS;
                  csb_q   <= f_csb;
               end
            end
            ACCESS: begin
               if (gpio_global_csb) begin
                  state_q <= CAPTURE;
                  for (int p = 0; p < 2; p++) begin
                     if (rd[p]) dout_q[p] <= dout_in[p];
                  end
               end else begin
                  csb_q <= f_csb;
               end
            end
            CAPTURE: begin
               if (gpio_sram_load) begin
                  state_q <= IDLE;
               end else if (gpio_scan) begin
                  state_q <= SHIFT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gpio_out  = scan_q[FRAME_W-1];
   assign sel       = frame_q[FRAME_W-1 -: SEL_W];
   assign csb_0     = csb_q[0];
   assign web_0     = f_web[0];
   assign wmask_0   = f_wmask[0];
   assign addr_0    = f_addr[0];
   assign din_0     = f_din[0];
   assign csb_1     = csb_q[1];
   assign web_1     = f_web[1];
   assign wmask_1   = f_wmask[1];
   assign addr_1    = f_addr[1];
   assign din_1     = f_din[1];
   assign frame_err = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Scoreboard bench: a two-port and a one-port controller driven by directed frames.
module tb_sram_scan_ctrl;

   typedef struct packed {
      logic [3:0]  sel;
      logic        port;
      logic [15:0] addr;
      logic [31:0] din;
      logic        web;
      logic [3:0]  wmask;
   } acc_t;

   logic clk = 1'b0;
   logic rst_n;
   logic scan_s [2];
   logic ld_s   [2];
   logic gcsb_s [2];
   logic gin_s  [2];

   logic [31:0] d0_dout_0, d0_dout_1, d1_dout_0, d1_dout_1;

   logic        d0_gpio_out, d0_csb_0, d0_web_0, d0_csb_1, d0_web_1, d0_err, d0_busy;
   logic [3:0]  d0_sel, d0_wmask_0, d0_wmask_1;
   logic [15:0] d0_addr_0, d0_addr_1;
   logic [31:0] d0_din_0, d0_din_1;

   logic        d1_gpio_out, d1_csb_0, d1_web_0, d1_csb_1, d1_web_1, d1_err, d1_busy;
   logic [3:0]  d1_sel, d1_wmask_0, d1_wmask_1;
   logic [15:0] d1_addr_0, d1_addr_1;
   logic [31:0] d1_din_0, d1_din_1;

   int total = 0;
   int bad   = 0;

   acc_t           accq0 [$];
   acc_t           accq1 [$];
   logic [111:0]   scanq0 [$];
   logic [57:0]    scanq1 [$];
   logic           obs [2];
   logic [111:0]   sbuf0;
   logic [57:0]    sbuf1;
   int             n0 = 0;
   int             n1 = 0;
   logic           d1_csb1_low = 1'b0;

   always #5 clk = ~clk;

   sram_scan_ctrl #(.NUM_PORTS(2)) dut0 (
      .gpio_clk(clk), .gpio_resetn(rst_n), .gpio_scan(scan_s[0]), .gpio_sram_load(ld_s[0]),
      .gpio_global_csb(gcsb_s[0]), .gpio_in(gin_s[0]), .gpio_out(d0_gpio_out), .sel(d0_sel),
      .csb_0(d0_csb_0), .web_0(d0_web_0), .wmask_0(d0_wmask_0), .addr_0(d0_addr_0),
      .din_0(d0_din_0), .dout_0(d0_dout_0),
      .csb_1(d0_csb_1), .web_1(d0_web_1), .wmask_1(d0_wmask_1), .addr_1(d0_addr_1),
      .din_1(d0_din_1), .dout_1(d0_dout_1),
      .frame_err(d0_err), .busy(d0_busy)
   );

   sram_scan_ctrl #(.NUM_PORTS(1)) dut1 (
      .gpio_clk(clk), .gpio_resetn(rst_n), .gpio_scan(scan_s[1]), .gpio_sram_load(ld_s[1]),
      .gpio_global_csb(gcsb_s[1]), .gpio_in(gin_s[1]), .gpio_out(d1_gpio_out), .sel(d1_sel),
      .csb_0(d1_csb_0), .web_0(d1_web_0), .wmask_0(d1_wmask_0), .addr_0(d1_addr_0),
      .din_0(d1_din_0), .dout_0(d1_dout_0),
      .csb_1(d1_csb_1), .web_1(d1_web_1), .wmask_1(d1_wmask_1), .addr_1(d1_addr_1),
      .din_1(d1_din_1), .dout_1(d1_dout_1),
      .frame_err(d1_err), .busy(d1_busy)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [111:0] mk2(
      input logic [3:0] s,
      input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
      input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
      return {s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
   endfunction

   function automatic logic [57:0] mk1(input logic [3:0] s, input logic [15:0] a, input logic [31:0] d,
                                       input logic c, input logic w, input logic [3:0] m);
      return {s, a, d, c, w, m};
   endfunction

   function automatic acc_t mkacc(input logic [3:0] s, input logic p, input logic [15:0] a,
                                  input logic [31:0] d, input logic w, input logic [3:0] m);
      acc_t r;
      r.sel = s; r.port = p; r.addr = a; r.din = d; r.web = w; r.wmask = m;
      return r;
   endfunction

   // All drive tasks start and end at posedge+1.
   task automatic shift_frame(input int d, input logic [111:0] f, input int n, input bit keep);
      for (int i = n - 1; i >= 0; i--) begin
         scan_s[d] = 1'b1;
         gin_s[d]  = f[i];
         @(posedge clk); #1;
      end
      if (!keep) begin
         scan_s[d] = 1'b0;
         gin_s[d]  = 1'b0;
      end
   endtask

   task automatic pulse_csb(input int d);
      @(posedge clk); #1;
      gcsb_s[d] = 1'b0;
      @(posedge clk); #1;
      gcsb_s[d] = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_pulse(input int d);
      ld_s[d] = 1'b1;
      @(posedge clk); #1;
      ld_s[d] = 1'b0;
   endtask

   task automatic mon_acc0(input int p);
      acc_t e;
      if (accq0.size() == 0) begin
         total++; bad++;
         $display("FAIL acc0_unexpected port=%0d actual=csb_low required=csb_high", p);
      end else begin
         e = accq0.pop_front();
         chk("acc0_port", 128'(p), 128'(e.port));
         chk("acc0_sel", 128'(d0_sel), 128'(e.sel));
         chk("acc0_addr", 128'(p ? d0_addr_1 : d0_addr_0), 128'(e.addr));
         chk("acc0_din", 128'(p ? d0_din_1 : d0_din_0), 128'(e.din));
         chk("acc0_web", 128'(p ? d0_web_1 : d0_web_0), 128'(e.web));
         chk("acc0_wmask", 128'(p ? d0_wmask_1 : d0_wmask_0), 128'(e.wmask));
      end
   endtask

   task automatic mon_acc1;
      acc_t e;
      if (accq1.size() == 0) begin
         total++; bad++;
         $display("FAIL acc1_unexpected actual=csb_low required=csb_high");
      end else begin
         e = accq1.pop_front();
         chk("acc1_sel", 128'(d1_sel), 128'(e.sel));
         chk("acc1_addr", 128'(d1_addr_0), 128'(e.addr));
         chk("acc1_din", 128'(d1_din_0), 128'(e.din));
         chk("acc1_web", 128'(d1_web_0), 128'(e.web));
         chk("acc1_wmask", 128'(d1_wmask_0), 128'(e.wmask));
      end
   endtask

   // Monitor: macro strobes and scanned-out frames are matched against the queues.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (d0_csb_0 === 1'b0) mon_acc0(0);
         if (d0_csb_1 === 1'b0) mon_acc0(1);
         if (d1_csb_0 === 1'b0) mon_acc1();
         if (d1_csb_1 !== 1'b1) d1_csb1_low = 1'b1;
         if (obs[0] && scan_s[0]) begin
            sbuf0 = {sbuf0[110:0], d0_gpio_out};
            n0++;
            if (n0 == 112) begin
               n0 = 0;
               if (scanq0.size() == 0) begin
                  total++; bad++;
                  $display("FAIL scan0_unexpected actual=frame required=none");
               end else chk("scan0_frame", 128'(sbuf0), 128'(scanq0.pop_front()));
            end
         end
         if (obs[1] && scan_s[1]) begin
            sbuf1 = {sbuf1[56:0], d1_gpio_out};
            n1++;
            if (n1 == 58) begin
               n1 = 0;
               if (scanq1.size() == 0) begin
                  total++; bad++;
                  $display("FAIL scan1_unexpected actual=frame required=none");
               end else chk("scan1_frame", 128'(sbuf1), 128'(scanq1.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [111:0] f, fb;
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         scan_s[d] = 1'b0; ld_s[d] = 1'b0; gcsb_s[d] = 1'b1; gin_s[d] = 1'b0; obs[d] = 1'b0;
      end
      d0_dout_0 = '0; d0_dout_1 = '0; d1_dout_0 = '0; d1_dout_1 = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_csb_0", 128'(d0_csb_0), 128'(1));
      chk("rst_csb_1", 128'(d0_csb_1), 128'(1));
      chk("rst_gpio_out", 128'(d0_gpio_out), 128'(0));
      chk("rst_busy", 128'(d0_busy), 128'(0));
      chk("rst_frame_err", 128'(d0_err), 128'(0));
      chk("rst_sel", 128'(d0_sel), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-port write on port 0.
      f = mk2(4'd3, 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0);
      accq0.push_back(mkacc(4'd3, 1'b0, 16'd1, 32'hDEADBEEF, 1'b0, 4'hF));
      shift_frame(0, f, 112, 1'b0);
      pulse_csb(0);
      chk("wr_frame_err", 128'(d0_err), 128'(0));
      chk("wr_busy_capture", 128'(d0_busy), 128'(1));
      chk("wr_addr_hold", 128'(d0_addr_0), 128'(16'd1));
      chk("wr_din_hold", 128'(d0_din_0), 128'(32'hDEADBEEF));
      load_pulse(0);
      chk("wr_busy_idle", 128'(d0_busy), 128'(0));

      // Dual-port read, then scan the frame back out with read data folded in.
      d0_dout_0 = 32'h1;
      d0_dout_1 = 32'h8;
      f = mk2(4'd5, 16'd1, 32'd0, 1'b0, 1'b1, 4'h0, 16'd2, 32'd0, 1'b0, 1'b1, 4'h0);
      accq0.push_back(mkacc(4'd5, 1'b0, 16'd1, 32'd0, 1'b1, 4'h0));
      accq0.push_back(mkacc(4'd5, 1'b1, 16'd2, 32'd0, 1'b1, 4'h0));
      shift_frame(0, f, 112, 1'b0);
      pulse_csb(0);
      load_pulse(0);
      scanq0.push_back(mk2(4'd5, 16'd1, 32'h1, 1'b0, 1'b1, 4'h0, 16'd2, 32'h8, 1'b0, 1'b1, 4'h0));
      obs[0] = 1'b1;
      shift_frame(0, '0, 112, 1'b0);
      obs[0] = 1'b0;

      // Load and scan together clear the counter without shifting.
      shift_frame(0, 112'h1F, 5, 1'b1);
      load_pulse(0);
      f = mk2(4'd9, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0, 16'h55, 32'hCAFEF00D, 1'b0, 1'b0, 4'h3);
      accq0.push_back(mkacc(4'd9, 1'b1, 16'h55, 32'hCAFEF00D, 1'b0, 4'h3));
      shift_frame(0, f, 112, 1'b0);
      pulse_csb(0);
      chk("ldscan_frame_err", 128'(d0_err), 128'(0));
      load_pulse(0);

      // Two frames back-to-back: the second one wins.
      f  = mk2(4'd1, 16'h10, 32'h11111111, 1'b0, 1'b0, 4'h1, 16'h0, 32'h0, 1'b1, 1'b0, 4'h0);
      fb = mk2(4'd2, 16'h20, 32'h22222222, 1'b0, 1'b0, 4'h2, 16'h21, 32'h33333333, 1'b0, 1'b0, 4'h4);
      shift_frame(0, f, 112, 1'b1);
      shift_frame(0, fb, 112, 1'b0);
      @(posedge clk); #1;
      chk("b2b_armed_busy", 128'(d0_busy), 128'(1));
      chk("b2b_sel", 128'(d0_sel), 128'(4'd2));
      chk("b2b_addr_0", 128'(d0_addr_0), 128'(16'h20));
      chk("b2b_din_1", 128'(d0_din_1), 128'(32'h33333333));
      accq0.push_back(mkacc(4'd2, 1'b0, 16'h20, 32'h22222222, 1'b0, 4'h2));
      accq0.push_back(mkacc(4'd2, 1'b1, 16'h21, 32'h33333333, 1'b0, 4'h4));
      pulse_csb(0);
      load_pulse(0);

      // Short frame flags an error; the error then blocks arming of a good frame.
      f = mk2(4'd6, 16'h30, 32'h0, 1'b0, 1'b0, 4'hF, 16'h31, 32'h0, 1'b0, 1'b0, 4'hF);
      shift_frame(0, f, 111, 1'b0);
      pulse_csb(0);
      chk("short_frame_err", 128'(d0_err), 128'(1));
      chk("short_busy", 128'(d0_busy), 128'(0));
      shift_frame(0, f, 112, 1'b0);
      pulse_csb(0);
      chk("err_block_busy", 128'(d0_busy), 128'(0));
      chk("err_sticky", 128'(d0_err), 128'(1));
      rst_n = 1'b0;
      #1 chk("err_clear_rst", 128'(d0_err), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of an access.
      f = mk2(4'd7, 16'h44, 32'h0BADF00D, 1'b0, 1'b0, 4'hF, 16'h0, 32'h0, 1'b1, 1'b0, 4'h0);
      accq0.push_back(mkacc(4'd7, 1'b0, 16'h44, 32'h0BADF00D, 1'b0, 4'hF));
      shift_frame(0, f, 112, 1'b0);
      @(posedge clk); #1;
      gcsb_s[0] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstacc_csb_0", 128'(d0_csb_0), 128'(1));
      chk("rstacc_frame_err", 128'(d0_err), 128'(0));
      chk("rstacc_busy", 128'(d0_busy), 128'(0));
      @(posedge clk); #1;
      gcsb_s[0] = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      f = mk2(4'd8, 16'h45, 32'h12345678, 1'b0, 1'b0, 4'h1, 16'h0, 32'h0, 1'b1, 1'b0, 4'h0);
      accq0.push_back(mkacc(4'd8, 1'b0, 16'h45, 32'h12345678, 1'b0, 4'h1));
      shift_frame(0, f, 112, 1'b0);
      pulse_csb(0);
      chk("postrst_frame_err", 128'(d0_err), 128'(0));
      load_pulse(0);

      // Single-port build: write then read back addr 7.
      accq1.push_back(mkacc(4'd1, 1'b0, 16'd7, 32'h12345678, 1'b0, 4'hF));
      shift_frame(1, 112'(mk1(4'd1, 16'd7, 32'h12345678, 1'b0, 1'b0, 4'hF)), 58, 1'b0);
      pulse_csb(1);
      load_pulse(1);
      d1_dout_0 = 32'hA5A5A5A5;
      accq1.push_back(mkacc(4'd1, 1'b0, 16'd7, 32'h0, 1'b1, 4'h0));
      shift_frame(1, 112'(mk1(4'd1, 16'd7, 32'h0, 1'b0, 1'b1, 4'h0)), 58, 1'b0);
      pulse_csb(1);
      load_pulse(1);
      scanq1.push_back(mk1(4'd1, 16'd7, 32'hA5A5A5A5, 1'b0, 1'b1, 4'h0));
      obs[1] = 1'b1;
      shift_frame(1, '0, 58, 1'b0);
      obs[1] = 1'b0;
      chk("p1_frame_err", 128'(d1_err), 128'(0));

      repeat (3) @(posedge clk);
      #1;
      chk("acc0_left", 128'(accq0.size()), 128'(0));
      chk("acc1_left", 128'(accq1.size()), 128'(0));
      chk("scan0_left", 128'(scanq0.size()), 128'(0));
      chk("scan1_left", 128'(scanq1.size()), 128'(0));
      chk("np1_csb_1_low", 128'(d1_csb1_low), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_scan_ctrl.md
SRAM_SCAN_CTRL -- requirements
Module: sram_scan_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 4, meaning SRAM select field width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning per-port address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning per-port data width.
REQ-004 SHALL have parameter WMASK_W, default 4, meaning per-port write-mask width.
REQ-005 SHALL have parameter NUM_PORTS, default 2, legal values 1 or 2, meaning active SRAM ports.
REQ-006 SHALL derive FRAME_W = SEL_W + NUM_PORTS*(ADDR_W+DATA_W+2+WMASK_W), which is 112 at defaults.
REQ-007 SHALL have port gpio_clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-008 SHALL have port gpio_resetn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have ports gpio_scan, gpio_sram_load, gpio_global_csb and gpio_in: inputs, 1 bit each, for scan enable, dout load, access strobe (active low) and serial data in.
REQ-010 SHALL have port gpio_out, output, 1 bit: serial data out, always equal to scan_reg[FRAME_W-1].
REQ-011 SHALL have port sel, output, SEL_W bits: select field.
REQ-012 SHALL have, per port p, outputs csb_p (1), web_p (1), wmask_p (WMASK_W), addr_p (ADDR_W) and din_p (DATA_W), plus input dout_p (DATA_W); port-1 signals are tied inactive (csb_1=1) when NUM_PORTS=1.
REQ-013 SHALL have port frame_err, output, 1 bit: sticky flag for a malformed frame.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL lay out the frame MSB-first as {sel, then per port p=0..NUM_PORTS-1: addr, din, csb, web, wmask}.
REQ-016 SHALL shift scan_reg <= {scan_reg[FRAME_W-2:0], gpio_in} on every cycle with gpio_scan=1, regardless of FSM state.
REQ-017 SHALL keep a shift counter that counts modulo FRAME_W, wraps FRAME_W-1 -> 0, and clears on gpio_sram_load=1.
REQ-018 SHALL implement the FSM states IDLE, SHIFT, ARMED, ACCESS and CAPTURE.
REQ-019 IDLE->SHIFT SHALL occur on gpio_scan=1.
REQ-020 SHIFT->ARMED SHALL occur on gpio_scan=0 with counter==0.
REQ-021 SHIFT->IDLE SHALL occur on gpio_scan=0 with counter!=0, and SHALL set frame_err.
REQ-022 ARMED->ACCESS SHALL occur on gpio_global_csb=0; ACCESS SHALL persist while gpio_global_csb=0; ACCESS->CAPTURE SHALL occur on gpio_global_csb=1.
REQ-023 CAPTURE SHALL register dout_p into dout_q_p on the cycle it is entered, for each port with frame csb=0 and web=1.
REQ-024 ARMED/CAPTURE->IDLE SHALL occur on gpio_sram_load=1; in CAPTURE only, this SHALL also overwrite each read port's din field in scan_reg with dout_q_p, leaving all other fields unchanged.
REQ-025 gpio_scan=1 in ARMED or CAPTURE SHALL go to SHIFT and discard the pending access or capture.
REQ-026 csb_p SHALL be registered and low only while the FSM is in ACCESS and the frame csb field is 0, giving one cycle of latency from the sampled gpio_global_csb.
REQ-027 web_p, wmask_p, addr_p, din_p and sel SHALL hold the frame fields, stable from ARMED through CAPTURE.
REQ-028 gpio_sram_load and gpio_scan high in the same cycle SHALL give load priority, with no shift that cycle.
REQ-029 While frame_err=1, ARMED SHALL be unreachable and all csb_p SHALL stay 1.
REQ-030 Two ports addressing the same address with both web=0 SHALL be passed through unchanged; the SRAM defines the outcome.

Reset
REQ-031 gpio_resetn=0 SHALL immediately set: FSM IDLE, scan_reg 0, counter 0, dout_q 0, frame_err 0, csb_p 1, gpio_out 0 and busy 0.
REQ-032 Reset asserted mid-shift or mid-ACCESS SHALL abort with no further csb_p low pulse, and the first frame after release SHALL be accepted.

Verification
REQ-033 Shift a 112-bit write frame (sel=3, p0 addr=1 din=0xDEADBEEF csb=0 web=0, p1 csb=1), then pulse gpio_global_csb low for 1 cycle -> csb_0 low for exactly 1 cycle with addr_0=1 and din_0=0xDEADBEEF, csb_1=1, frame_err=0.
REQ-034 Send a read frame (p0 addr=1 web=1, p1 addr=2 web=1) with dout_0=0x1 and dout_1=0x8, then csb pulse and load, then shift 112 bits -> gpio_out reproduces the frame with din fields 0x00000001 and 0x00000008.
REQ-035 Shift 111 bits, then drop gpio_scan and pulse gpio_global_csb -> frame_err=1, FSM IDLE, no csb_p low.
REQ-036 Shift 224 bits back-to-back -> counter==0, ARMED entered, and the fields equal the second frame.
REQ-037 Assert gpio_resetn=0 during ACCESS -> csb_p=1 at once, frame_err=0; a following valid write frame completes normally.
REQ-038 With NUM_PORTS=1 (FRAME_W=58), a write followed by a read of 0xA5A5A5A5 at addr 7 -> scanned-out din field equals 0xA5A5A5A5, and csb_1 is 1 throughout.
